mem_wb_stage: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register fields: performs data-memory load/store using the EX/MEM ALU result as address, then registers the MEM/WB pipeline outputs for the write-back stage.
- Internal word-addressed data memory with configurable multi-cycle access latency; asserts mem_stall to freeze the upstream pipeline while an access is in flight.

---
 rtl/mem_wb_stage.sv | 152 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage: multi-cycle word-addressed data memory feeding the MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int MEM_WORDS = 64,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_MEM_ALU_Result,
  input  logic [4:0]  EX_MEM_RdAddr,
  input  logic [1:0]  EX_MEM_M,
  input  logic        EX_MEM_WB,
  input  logic [31:0] EX_MEM_StoreData,
  output logic        mem_stall,
  output logic [31:0] MEM_WB_ReadData,
  output logic [31:0] MEM_WB_ALU_Result,
  output logic [4:0]  MEM_WB_RdAddr,
  output logic        MEM_WB_WB,
  output logic        MEM_WB_MemToReg,
  output logic        misalign_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem [MEM_WORDS];

  logic [AW-1:0] idx;
  logic          is_op;
  logic          mis;
  logic          done;
  logic          we;
  logic          unused_addr;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_q, wb_d;
  logic        m2r_q, m2r_d;

  assign idx         = EX_MEM_ALU_Result[2 +: AW];
  assign is_op       = |EX_MEM_M;
  assign unused_addr = ^EX_MEM_ALU_Result;

`ifdef MEM_MISALIGN_CHECK_EN
  logic err_q, err_d;
  assign mis = is_op & (|EX_MEM_ALU_Result[1:0]);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (is_op && (MEM_LAT > 1)) begin
          state_d = BUSY;
          cnt_d   = CW'(MEM_LAT - 2);
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset silences the stall so upstream is never frozen while flushing.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE:    mem_stall = is_op && (MEM_LAT > 1);
      BUSY:    mem_stall = (cnt_q != '0);
      default: mem_stall = 1'b0;
    endcase
    mem_stall = mem_stall & rst_n;
  end

  assign done = rst_n & ~mem_stall;
  assign we   = done & EX_MEM_M[0] & ~mis;

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= EX_MEM_StoreData;
  end

  always_comb begin
    rdata_d = '0;
    alu_d   = '0;
    rd_d    = '0;
    wb_d    = 1'b0;
    m2r_d   = 1'b0;
    if (!mem_stall) begin
      if ((EX_MEM_M == 2'b10) && !mis) rdata_d = mem[idx];
      alu_d = EX_MEM_ALU_Result;
      rd_d  = EX_MEM_RdAddr;
      wb_d  = EX_MEM_WB & ~mis;
      m2r_d = EX_MEM_M[1] & ~EX_MEM_M[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      m2r_q   <= m2r_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign err_d = err_q | (done & mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign MEM_WB_ReadData   = rdata_q;
  assign MEM_WB_ALU_Result = alu_q;
  assign MEM_WB_RdAddr     = rd_q;
  assign MEM_WB_WB         = wb_q;
  assign MEM_WB_MemToReg   = m2r_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: MEM_LAT=2 and MEM_LAT=3 instances.
// Misaligned-access expectations follow MEM_MISALIGN_CHECK_EN.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu;
  logic [4:0]  rd;
  logic [1:0]  m;
  logic        wb;
  logic [31:0] sd;

  logic        s2, wb2, m2r2, err2;
  logic [31:0] rdat2, alu2;
  logic [4:0]  rda2;
  logic        s3, wb3, m2r3, err3;
  logic [31:0] rdat3, alu3;
  logic [4:0]  rda3;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.MEM_WORDS(64), .MEM_LAT(2)) d2 (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_ALU_Result(alu), .EX_MEM_RdAddr(rd),
    .EX_MEM_M(m), .EX_MEM_WB(wb), .EX_MEM_StoreData(sd),
    .mem_stall(s2), .MEM_WB_ReadData(rdat2),
    .MEM_WB_ALU_Result(alu2), .MEM_WB_RdAddr(rda2),
    .MEM_WB_WB(wb2), .MEM_WB_MemToReg(m2r2),
    .misalign_err(err2)
  );

  mem_wb_stage #(.MEM_WORDS(64), .MEM_LAT(3)) d3 (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_ALU_Result(alu), .EX_MEM_RdAddr(rd),
    .EX_MEM_M(m), .EX_MEM_WB(wb), .EX_MEM_StoreData(sd),
    .mem_stall(s3), .MEM_WB_ReadData(rdat3),
    .MEM_WB_ALU_Result(alu3), .MEM_WB_RdAddr(rda3),
    .MEM_WB_WB(wb3), .MEM_WB_MemToReg(m2r3),
    .misalign_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] mm,
                       input logic [4:0] r, input logic w,
                       input logic [31:0] d);
    alu = a; m = mm; rd = r; wb = w; sd = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 2'b00, 5'd0, 1'b0, 32'h0);
    tick();
    chk("rst_stall", 32'(s2), 32'h0);
    chk("rst_rdata", rdat2, 32'h0);
    chk("rst_alu", alu2, 32'h0);
    chk("rst_rd", 32'(rda2), 32'h0);
    chk("rst_wb", 32'(wb2), 32'h0);
    chk("rst_m2r", 32'(m2r2), 32'h0);
    chk("rst_err", 32'(err2), 32'h0);
    rst_n = 1'b1;

    // Store then load through the 2-cycle window
    drive(32'h08, 2'b01, 5'd3, 1'b0, 32'hCAFEF00D);
    chk("st_stall0", 32'(s2), 32'h1);
    tick();
    chk("st_stall1", 32'(s2), 32'h0);
    chk("st_bub_wb", 32'(wb2), 32'h0);
    chk("st_bub_rd", 32'(rda2), 32'h0);
    chk("st_bub_alu", alu2, 32'h0);
    tick();
    chk("st_alu", alu2, 32'h08);
    chk("st_m2r", 32'(m2r2), 32'h0);
    chk("st_rdata", rdat2, 32'h0);

    drive(32'h08, 2'b10, 5'd5, 1'b1, 32'h0);
    chk("ld_stall0", 32'(s2), 32'h1);
    tick();
    chk("ld_stall1", 32'(s2), 32'h0);
    tick();
    chk("ld_rdata", rdat2, 32'hCAFEF00D);
    chk("ld_rd", 32'(rda2), 32'd5);
    chk("ld_m2r", 32'(m2r2), 32'h1);
    chk("ld_wb", 32'(wb2), 32'h1);

    // Plain ALU op passes straight through
    drive(32'h1234, 2'b00, 5'd7, 1'b1, 32'hFFFF_FFFF);
    chk("alu_stall", 32'(s2), 32'h0);
    tick();
    chk("alu_alu", alu2, 32'h1234);
    chk("alu_rd", 32'(rda2), 32'd7);
    chk("alu_m2r", 32'(m2r2), 32'h0);
    chk("alu_rdata", rdat2, 32'h0);
    chk("alu_wb", 32'(wb2), 32'h1);

    // M=11 behaves as a store
    drive(32'h20, 2'b11, 5'd9, 1'b1, 32'hA5A5A5A5);
    chk("m11_stall", 32'(s2), 32'h1);
    tick();
    tick();
    chk("m11_m2r", 32'(m2r2), 32'h0);
    chk("m11_rdata", rdat2, 32'h0);
    chk("m11_wb", 32'(wb2), 32'h1);
    drive(32'h20, 2'b10, 5'd2, 1'b1, 32'h0);
    tick();
    tick();
    chk("m11_ld", rdat2, 32'hA5A5A5A5);

    // Misaligned store to 0x22, then aligned load of 0x20
    drive(32'h22, 2'b01, 5'd1, 1'b1, 32'h77);
    tick();
    tick();
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_wb", 32'(wb2), 32'h0);
    chk("mis_err", 32'(err2), 32'h1);
`else
    chk("mis_wb", 32'(wb2), 32'h1);
    chk("mis_err", 32'(err2), 32'h0);
`endif
    drive(32'h20, 2'b10, 5'd2, 1'b1, 32'h0);
    tick();
    tick();
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_ld", rdat2, 32'hA5A5A5A5);
    chk("mis_sticky", 32'(err2), 32'h1);
`else
    chk("mis_ld", rdat2, 32'h77);
    chk("mis_sticky", 32'(err2), 32'h0);
`endif

    // Reset in the middle of a store aborts it
    drive(32'h10, 2'b01, 5'd0, 1'b0, 32'h11111111);
    tick();
    tick();
    drive(32'h10, 2'b01, 5'd0, 1'b0, 32'hDEADBEEF);
    tick();
    chk("abort_busy", 32'(s2), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", 32'(s2), 32'h0);
    chk("abort_rdata", rdat2, 32'h0);
    chk("abort_alu", alu2, 32'h0);
    chk("abort_rd", 32'(rda2), 32'h0);
    chk("abort_wb", 32'(wb2), 32'h0);
    chk("abort_m2r", 32'(m2r2), 32'h0);
    chk("abort_err", 32'(err2), 32'h0);
    tick();
    drive(32'h0, 2'b00, 5'd0, 1'b0, 32'h0);
    rst_n = 1'b1;
    drive(32'h10, 2'b10, 5'd6, 1'b1, 32'h0);
    chk("abort_ld_stall", 32'(s2), 32'h1);
    tick();
    tick();
    chk("abort_ld", rdat2, 32'h11111111);

    // MEM_LAT=3 with address wrap
    rst_n = 1'b0;
    drive(32'h0, 2'b00, 5'd0, 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(32'h100, 2'b01, 5'd0, 1'b0, 32'h55);
    chk("l3_st_s0", 32'(s3), 32'h1);
    tick();
    chk("l3_st_s1", 32'(s3), 32'h1);
    chk("l3_st_bub", 32'(rda3), 32'h0);
    tick();
    chk("l3_st_s2", 32'(s3), 32'h0);
    tick();
    chk("l3_st_alu", alu3, 32'h100);
    chk("l3_st_rdata", rdat3, 32'h0);
    drive(32'h000, 2'b10, 5'd4, 1'b1, 32'h0);
    chk("l3_ld_s0", 32'(s3), 32'h1);
    tick();
    chk("l3_ld_s1", 32'(s3), 32'h1);
    chk("l3_ld_bubwb", 32'(wb3), 32'h0);
    tick();
    chk("l3_ld_s2", 32'(s3), 32'h0);
    tick();
    chk("l3_ld_rdata", rdat3, 32'h55);
    chk("l3_ld_rd", 32'(rda3), 32'd4);
    chk("l3_ld_m2r", 32'(m2r3), 32'h1);
    chk("l3_ld_wb", 32'(wb3), 32'h1);
    chk("l3_err", 32'(err3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
